ram_reader: RTL
===============

Name: ram_reader

Overview:
- Read-side sequencer for the 4x8 program RAM; the counterpart of the init writer that loads the RAM after reset.
- On a start pulse it walks addresses 0..DEPTH-1 and issues one read per word, honouring the RAM's synchronous read latency.
- Each captured word, with its address, is held for display (seven-segment/LEDs) and added into a running checksum.
- Advance is either manual (step pulse from a key) or automatic (fixed hold time). Used for post-init readback and board-level checking of RAM contents.

Parameters:
- ADDR_W, 2, RAM address width.
- DATA_W, 8, RAM data width.
- DEPTH, 4, number of words read per pass; legal range 1..2^ADDR_W.
- READ_LAT, 1, cycles from the rd_en sampling edge to valid rd_data; legal range 1..4.
- HOLD_CYCLES, 50000000, SHOW dwell in auto mode (1 s at 50 MHz); legal range ≥1.

Ports:
- clk, input, 1, system clock; all state on rising edge.
- clr, input, 1, asynchronous active-high reset.
- start, input, 1, single-cycle pulse; begins a pass.
- step, input, 1, single-cycle pulse; advance in manual mode.
- auto_mode, input, 1, 1 = timed advance, 0 = step advance; sampled only in SHOW.
- rd_en, output, 1, read strobe to RAM.
- rd_addr, output, ADDR_W, read address to RAM.
- rd_data, input, DATA_W, RAM data output.
- word_out, output, DATA_W, last captured word.
- word_addr, output, ADDR_W, address of word_out.
- word_valid, output, 1, high while in SHOW.
- sum, output, DATA_W+ADDR_W, running sum of captured words this pass.
- busy, output, 1, high in ISSUE/WAIT/SHOW.
- done, output, 1, high in DONE.

Behaviour:
- Reset (clr=1, asynchronous): state IDLE; rd_en=0, rd_addr=0, word_out=0, word_addr=0, word_valid=0, sum=0, busy=0, done=0; wait and hold counters = 0. Reset asserted mid-pass aborts immediately; no partial state survives.

States:
- IDLE: start=1 → clear sum, rd_addr=0 → ISSUE.
- ISSUE (1 cycle): rd_en=1, rd_addr stable → WAIT, wait counter = 0.
- WAIT (READ_LAT cycles): rd_en=0. On the last WAIT edge: word_out ← rd_data, word_addr ← rd_addr, sum ← sum + zero-extended rd_data → SHOW, hold counter = 0.
- SHOW: word_valid=1.
  - Manual (auto_mode=0): step=1 advances.
  - Auto (auto_mode=1): advance when the hold counter reaches HOLD_CYCLES-1; otherwise increment it.
  - Advance: if rd_addr == DEPTH-1 → DONE; else rd_addr+1 → ISSUE.
- DONE: done=1; word_out, word_addr and sum hold. start=1 → behaves as in IDLE (sum cleared, new pass).

Timing (READ_LAT=1):
- start sampled at edge k → ISSUE after k.
- RAM samples rd_en/rd_addr at edge k+1 → WAIT.
- Data captured at edge k+2 → word_valid=1 after k+2.
- General rule: word_valid rises READ_LAT+1 edges after the start edge.
- Per-word period in manual mode: 2+READ_LAT cycles plus the wait for step.

Input and boundary rules:
- start is ignored in ISSUE, WAIT and SHOW.
- step is ignored outside SHOW. A step in the same cycle SHOW is entered is not lost, because SHOW is only entered by the capture edge.
- If auto_mode changes during SHOW, the hold counter does not reset; auto advance uses its current value.
- Arithmetic: sum width DATA_W+ADDR_W cannot overflow for DEPTH ≤ 2^ADDR_W. rd_addr never wraps; passes terminate at DEPTH-1.
- rd_data is ignored outside the final WAIT cycle.
- DEPTH=1: a single ISSUE/WAIT/SHOW, then DONE.

Test Plan:
- RAM model preloaded 74,29,32,20 (READ_LAT=1), manual mode: start, then step once per SHOW → word_out/word_addr sequence 74/0, 29/1, 32/2, 20/3; sum ends at 155; done=1 after the 4th step; rd_en exactly 4 single-cycle pulses.
- Latency check: start at edge k → rd_en=1 in the cycle after k; word_valid=1 after edge k+2; repeat with READ_LAT=3 → word_valid after edge k+4 with correct data.
- Auto mode, HOLD_CYCLES=5, no steps → each SHOW lasts exactly 5 cycles; DONE reached with sum=155; step pulses injected during WAIT have no effect.
- Reset mid-pass: assert clr while in SHOW at address 2 → all outputs zero asynchronously, state IDLE; a new start reads from address 0 and sum restarts at 74.
- Restart from DONE with RAM changed to 255,255,255,255 → sum=1020 (fits in 10 bits); start pulses during busy ignored, leaving the address sequence uninterrupted.
- DEPTH=1: start → a single word 74 at address 0, then done=1, sum=74.

Source files
------------

// File: rtl/ram_reader.sv
// Read-side sequencer for the program RAM: walks addresses 0..DEPTH-1, captures
// each word after the RAM read latency, holds it for display and accumulates a checksum.
module ram_reader #(
  parameter int ADDR_W      = 2,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4,
  parameter int READ_LAT    = 1,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     start,
  input  logic                     step,
  input  logic                     auto_mode,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic [DATA_W-1:0]        rd_data,
  output logic [DATA_W-1:0]        word_out,
  output logic [ADDR_W-1:0]        word_addr,
  output logic                     word_valid,
  output logic [DATA_W+ADDR_W-1:0] sum,
  output logic                     busy,
  output logic                     done
);

  localparam int SUM_W  = DATA_W + ADDR_W;
  localparam int WAIT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_LAT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_SHOW,
    S_DONE
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              show_advance;
  logic              last_word;
  logic              wait_last;

  // Manual mode advances on step; auto mode after the dwell counter expires.
  assign show_advance = auto_mode ? (hold_cnt == HOLD_LAST) : step;
  assign last_word    = (rd_addr == LAST_ADDR);
  assign wait_last    = (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= S_IDLE;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      word_out   <= '0;
      word_addr  <= '0;
      word_valid <= 1'b0;
      sum        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wait_cnt   <= '0;
      hold_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state   <= S_ISSUE;
            sum     <= '0;
            rd_addr <= '0;
            rd_en   <= 1'b1;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end

        S_ISSUE: begin
          state    <= S_WAIT;
          rd_en    <= 1'b0;
          wait_cnt <= '0;
        end

        S_WAIT: begin
          // rd_data is only trusted on the final latency edge.
          if (wait_last) begin
            state      <= S_SHOW;
            word_out   <= rd_data;
            word_addr  <= rd_addr;
            sum        <= sum + SUM_W'(rd_data);
            word_valid <= 1'b1;
            hold_cnt   <= '0;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        S_SHOW: begin
          if (show_advance) begin
            word_valid <= 1'b0;
            if (last_word) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state   <= S_ISSUE;
              rd_addr <= rd_addr + ADDR_W'(1);
              rd_en   <= 1'b1;
            end
          end else if (auto_mode) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        default: begin
          state      <= S_IDLE;
          rd_en      <= 1'b0;
          word_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule
